// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: packed BCD time, lap FSM states and per-digit limits.
package stopwatch_pkg;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] DIGIT_MAX_HI = 4'd5;

  typedef struct packed {
    logic [3:0] d3;  // 0-5 digit
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_time_t;

  typedef enum logic [0:0] {
    LIVE   = 1'b0,
    RECALL = 1'b1
  } lap_state_t;

endpackage

// File: rtl/lap_recorder_if.sv
// Button/display bundle between the debounce stage, lap_recorder and the display.
import stopwatch_pkg::*;

interface lap_recorder_if #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
);
  bcd_time_t        live_time;
  logic             lap_pulse;
  logic             recall_pulse;
  logic             clear_pulse;
  bcd_time_t        display_time;
  logic             showing_lap;
  logic [IDX_W-1:0] lap_index;
  logic [IDX_W:0]   lap_count;
  logic             full;
  logic             overflow;

  modport master (
    output live_time, lap_pulse, recall_pulse, clear_pulse,
    input  display_time, showing_lap, lap_index, lap_count, full, overflow
  );

  modport slave (
    input  live_time, lap_pulse, recall_pulse, clear_pulse,
    output display_time, showing_lap, lap_index, lap_count, full, overflow
  );
endinterface

// File: rtl/lap_buffer.sv
// DEPTH x 16 lap storage: synchronous write, combinational read, no reset on contents.
import stopwatch_pkg::*;

module lap_buffer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  bcd_time_t        wdata,
  input  logic [IDX_W-1:0] raddr,
  output bcd_time_t        rdata
);

  bcd_time_t mem_r [DEPTH];

  // Slot write; contents are meaningless until lap_count covers them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/lap_recorder.sv
// Lap capture buffer and live/recall display selector for the stopwatch.
// Build option LAP_OVERWRITE_EN: a lap taken while full replaces the oldest entry.
import stopwatch_pkg::*;

module lap_recorder #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           master_reset_n,
  lap_recorder_if.slave  bus
);

  localparam int             CW      = IDX_W + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  lap_state_t       state_r, state_s;
  logic [IDX_W-1:0] wr_ptr_r, wr_ptr_s;
  logic [IDX_W-1:0] lap_index_r, lap_index_s;
  logic [IDX_W-1:0] oldest_s, raddr_s;
  logic [CW-1:0]    lap_count_r, lap_count_s;
  logic             full_r, full_s;
  logic             overflow_r, overflow_s;
  logic             showing_r;
  logic             capture_s, we_s;
  bcd_time_t        display_r, display_s;
  bcd_time_t        rdata_s, slot_s;

  lap_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_buffer (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (bus.live_time),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next-state: clear beats lap beats recall; recall sees the post-capture count.
  always_comb begin
    capture_s = bus.lap_pulse && !bus.clear_pulse;
`ifdef LAP_OVERWRITE_EN
    we_s = capture_s;
`else
    we_s = capture_s && !full_r;
`endif
    wr_ptr_s    = we_s ? (wr_ptr_r + IDX_W'(1)) : wr_ptr_r;
    lap_count_s = (capture_s && !full_r) ? (lap_count_r + CW'(1)) : lap_count_r;
    overflow_s  = overflow_r | (capture_s & full_r);
    state_s     = state_r;
    lap_index_s = lap_index_r;

    if (bus.clear_pulse) begin
      state_s     = LIVE;
      lap_index_s = '0;
      wr_ptr_s    = '0;
      lap_count_s = '0;
      overflow_s  = 1'b0;
    end else if (bus.recall_pulse) begin
      if (state_r == LIVE) begin
        if (lap_count_s != '0) begin
          state_s     = RECALL;
          lap_index_s = '0;
        end else begin
          state_s     = LIVE;
          lap_index_s = '0;
        end
      end else if (({1'b0, lap_index_r} + CW'(1)) < lap_count_s) begin
        lap_index_s = lap_index_r + IDX_W'(1);
      end else begin
        state_s     = LIVE;
        lap_index_s = '0;
      end
    end else begin
      state_s     = state_r;
      lap_index_s = lap_index_r;
    end

    // Oldest is relative to the post-capture pointer, so an overwrite shifts the mapping.
    oldest_s = wr_ptr_s - lap_count_s[IDX_W-1:0];
    raddr_s  = oldest_s + lap_index_s;

    // The slot being written this edge is not in storage yet; forward it.
    if (we_s && (raddr_s == wr_ptr_r)) begin
      slot_s = bus.live_time;
    end else begin
      slot_s = rdata_s;
    end

    if (state_s == RECALL) begin
      display_s = slot_s;
    end else begin
      display_s = bus.live_time;
    end

    full_s = (lap_count_s == DEPTH_C);
  end

  // State, pointers and all registered outputs.
  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state_r     <= LIVE;
      wr_ptr_r    <= '0;
      lap_index_r <= '0;
      lap_count_r <= '0;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      showing_r   <= 1'b0;
      display_r   <= '0;
    end else begin
      state_r     <= state_s;
      wr_ptr_r    <= wr_ptr_s;
      lap_index_r <= lap_index_s;
      lap_count_r <= lap_count_s;
      full_r      <= full_s;
      overflow_r  <= overflow_s;
      showing_r   <= (state_s == RECALL);
      display_r   <= display_s;
    end
  end

  assign bus.display_time = display_r;
  assign bus.showing_lap  = showing_r;
  assign bus.lap_index    = lap_index_r;
  assign bus.lap_count    = lap_count_r;
  assign bus.full         = full_r;
  assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: a list-based lap model feeds an expectation queue.
import stopwatch_pkg::*;

module tb_lap_recorder;

  localparam int DEPTH = 8;

  typedef struct {
    logic [15:0] disp;
    logic        show;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    logic        full;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  exp_t        exp_q [$];
  logic [15:0] laps [$];
  bit          m_show;
  int          m_idx;
  bit          m_ovf;

  lap_recorder_if #(.DEPTH(DEPTH)) bus ();

  lap_recorder #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .master_reset_n (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    laps.delete();
    m_show = 1'b0;
    m_idx  = 0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input logic [15:0] live, input bit lap, input bit rec, input bit clr);
    exp_t e;
    @(negedge clk);
    bus.live_time    = live;
    bus.lap_pulse    = lap;
    bus.recall_pulse = rec;
    bus.clear_pulse  = clr;
    if (clr) begin
      laps.delete();
      m_ovf  = 1'b0;
      m_show = 1'b0;
      m_idx  = 0;
    end else begin
      if (lap) begin
        if (laps.size() < DEPTH) begin
          laps.push_back(live);
        end else begin
          m_ovf = 1'b1;
`ifdef LAP_OVERWRITE_EN
          void'(laps.pop_front());
          laps.push_back(live);
`endif
        end
      end
      if (rec) begin
        if (!m_show) begin
          if (laps.size() > 0) begin
            m_show = 1'b1;
            m_idx  = 0;
          end
        end else if (m_idx + 1 < laps.size()) begin
          m_idx = m_idx + 1;
        end else begin
          m_show = 1'b0;
          m_idx  = 0;
        end
      end
    end
    e.disp = m_show ? laps[m_idx] : live;
    e.show = m_show;
    e.idx  = 3'(m_idx);
    e.cnt  = 4'(laps.size());
    e.full = (laps.size() == DEPTH);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if (bus.display_time !== 16'h0000 || bus.showing_lap !== 1'b0 || bus.lap_index !== 3'd0 ||
        bus.lap_count !== 4'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got disp=%h show=%b idx=%0d cnt=%0d full=%b ovf=%b, want all zero",
               tag, bus.display_time, bus.showing_lap, bus.lap_index, bus.lap_count,
               bus.full, bus.overflow);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whenever an expectation is pending.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_t e;
        bit   bad;
        e   = exp_q.pop_front();
        bad = 1'b0;
        vectors++;
        if (bus.display_time !== e.disp) begin
          bad = 1'b1;
          $display("FAIL display_time cyc %0d: got %h want %h", cyc, bus.display_time, e.disp);
        end
        if (bus.showing_lap !== e.show) begin
          bad = 1'b1;
          $display("FAIL showing_lap cyc %0d: got %b want %b", cyc, bus.showing_lap, e.show);
        end
        if (bus.lap_index !== e.idx) begin
          bad = 1'b1;
          $display("FAIL lap_index cyc %0d: got %0d want %0d", cyc, bus.lap_index, e.idx);
        end
        if (bus.lap_count !== e.cnt) begin
          bad = 1'b1;
          $display("FAIL lap_count cyc %0d: got %0d want %0d", cyc, bus.lap_count, e.cnt);
        end
        if (bus.full !== e.full) begin
          bad = 1'b1;
          $display("FAIL full cyc %0d: got %b want %b", cyc, bus.full, e.full);
        end
        if (bus.overflow !== e.ovf) begin
          bad = 1'b1;
          $display("FAIL overflow cyc %0d: got %b want %b", cyc, bus.overflow, e.ovf);
        end
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    bus.live_time    = 16'h0000;
    bus.lap_pulse    = 1'b0;
    bus.recall_pulse = 1'b0;
    bus.clear_pulse  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Live pass-through
    step(16'h2345, 1'b0, 1'b0, 1'b0);
    step(16'h2346, 1'b0, 1'b0, 1'b0);

    // Two laps, walk through them and back to live
    step(16'h0012, 1'b1, 1'b0, 1'b0);
    step(16'h0107, 1'b1, 1'b0, 1'b0);
    step(16'h0110, 1'b0, 1'b1, 1'b0);
    step(16'h0111, 1'b0, 1'b1, 1'b0);
    step(16'h0112, 1'b0, 1'b1, 1'b0);
    step(16'h0113, 1'b0, 1'b0, 1'b0);

    // Nine laps into eight slots, then recall through all of them
    step(16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) step(16'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(16'h0500, 1'b0, 1'b1, 1'b0);

    // clear+lap with three laps stored
    step(16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(16'h0020 + 16'(i), 1'b1, 1'b0, 1'b0);
    step(16'h0099, 1'b1, 1'b0, 1'b1);
    step(16'h0100, 1'b0, 1'b1, 1'b0);

    // lap+recall with an empty buffer
    step(16'h0000, 1'b0, 1'b0, 1'b1);
    step(16'h0345, 1'b1, 1'b1, 1'b0);
    step(16'h0346, 1'b0, 1'b0, 1'b0);

    // Async reset mid-RECALL, between edges
    step(16'h0201, 1'b1, 1'b0, 1'b0);
    step(16'h0202, 1'b0, 1'b1, 1'b0);
    step(16'h0203, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.lap_pulse    = 1'b0;
    bus.recall_pulse = 1'b0;
    bus.clear_pulse  = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset_mid_recall");
    #1 rst_n = 1'b1;
    model_reset();
    step(16'h0300, 1'b0, 1'b1, 1'b0);
    step(16'h0301, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(16'($urandom_range(0, 16'hFFFF)),
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 3);
    end
    step(16'h0000, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
